// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer for the MEM stage.
// A taken exception or ERET holds the pipeline and then runs three steps:
//   exception: EPC write -> Status write (EXL set)   -> flush to EXC_VECTOR
//   ERET:                   Status write (EXL clear) -> flush to latched EPC
// Optional macro EXC_CP0_FWD_EN: forward an in-flight WB CP0 write into the
// Status/Cause/EPC values seen here. Without it, wb_cp0_* are ignored.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] DS_OFFSET  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_is_delayslot_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_trap_i,
  input  logic        exc_syscall_i,
  input  logic        exc_eret_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic        stall_req_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_data_o,
  output logic [4:0]  exc_code_o,
  output logic        exc_bd_o
);

  typedef enum logic [1:0] {IDLE, SAVE_EPC, SET_STATUS, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [31:0] st_eff, ca_eff, epc_eff;
  logic [31:0] pc_q, epc_q;
  logic        bd_q, eret_q;
  logic        int_pend, exc_any, take_exc, take_eret;
  logic [4:0]  code_nxt;

`ifdef EXC_CP0_FWD_EN
  // Effective CP0 view: a same-cycle WB write wins; Cause only exposes IP[1:0], IV, WP.
  always_comb begin
    st_eff  = status_i;
    ca_eff  = cause_i;
    epc_eff = epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        5'd12: st_eff = wb_cp0_data_i;
        5'd13: begin
          ca_eff[23]  = wb_cp0_data_i[23];
          ca_eff[22]  = wb_cp0_data_i[22];
          ca_eff[9:8] = wb_cp0_data_i[9:8];
        end
        5'd14: epc_eff = wb_cp0_data_i;
        default: ;
      endcase
    end
  end
`else
  assign st_eff  = status_i;
  assign ca_eff  = cause_i;
  assign epc_eff = epc_i;
  logic unused_wb;
  assign unused_wb = ^{wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i};
`endif

  logic unused_cause;
  assign unused_cause = ^{ca_eff[31:16], ca_eff[7:0]};

  assign int_pend  = st_eff[0] & ~st_eff[1] & (|(ca_eff[15:8] & st_eff[15:8]));
  assign exc_any   = int_pend | exc_ri_i | exc_ov_i | exc_trap_i | exc_syscall_i;
  assign take_exc  = (state == IDLE) & mem_valid_i & exc_any;
  assign take_eret = (state == IDLE) & mem_valid_i & ~exc_any & exc_eret_i;

  // Fixed priority encode of the exception cause.
  always_comb begin
    code_nxt = 5'd8;
    if (int_pend)        code_nxt = 5'd0;
    else if (exc_ri_i)   code_nxt = 5'd10;
    else if (exc_ov_i)   code_nxt = 5'd12;
    else if (exc_trap_i) code_nxt = 5'd13;
  end

  // State register and per-event latches (PC, BD, code, EPC target).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc_q       <= '0;
      bd_q       <= 1'b0;
      eret_q     <= 1'b0;
      epc_q      <= '0;
      exc_code_o <= '0;
      exc_bd_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_exc) begin
        pc_q       <= mem_pc_i;
        bd_q       <= mem_is_delayslot_i;
        eret_q     <= 1'b0;
        exc_code_o <= code_nxt;
        exc_bd_o   <= mem_is_delayslot_i;
      end else if (take_eret) begin
        epc_q  <= epc_eff;
        eret_q <= 1'b1;
      end
    end
  end

  // Next state and per-state CP0 write / redirect outputs.
  always_comb begin
    state_nxt   = state;
    cp0_we_o    = 1'b0;
    cp0_waddr_o = '0;
    cp0_data_o  = '0;
    flush_o     = 1'b0;
    new_pc_o    = '0;
    case (state)
      IDLE: begin
        if (take_exc)       state_nxt = SAVE_EPC;
        else if (take_eret) state_nxt = SET_STATUS;
      end
      SAVE_EPC: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = 5'd14;
        cp0_data_o  = bd_q ? (pc_q - DS_OFFSET) : pc_q;
        state_nxt   = SET_STATUS;
      end
      SET_STATUS: begin
        cp0_we_o    = 1'b1;
        cp0_waddr_o = 5'd12;
        cp0_data_o  = eret_q ? (st_eff & ~32'h2) : (st_eff | 32'h2);
        state_nxt   = REDIRECT;
      end
      REDIRECT: begin
        flush_o   = 1'b1;
        new_pc_o  = eret_q ? epc_q : EXC_VECTOR;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold request is combinational; gated by reset so it drops immediately.
  assign stall_req_o = rst & ((state != IDLE) | take_exc | take_eret);

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: expected CP0 writes and flushes are queued
// when an event is driven and popped by a negedge monitor as the DUT emits them.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_pc_i = '0;
  logic        mem_is_delayslot_i = 1'b0;
  logic        exc_ri_i = 1'b0, exc_ov_i = 1'b0, exc_trap_i = 1'b0;
  logic        exc_syscall_i = 1'b0, exc_eret_i = 1'b0;
  logic [31:0] status_i = '0, cause_i = '0, epc_i = '0;
  logic        wb_cp0_we_i = 1'b0;
  logic [4:0]  wb_cp0_waddr_i = '0;
  logic [31:0] wb_cp0_data_i = '0;
  logic        stall_req_o, flush_o, cp0_we_o, exc_bd_o;
  logic [31:0] new_pc_o, cp0_data_o;
  logic [4:0]  cp0_waddr_o, exc_code_o;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_is_delayslot_i(mem_is_delayslot_i), .exc_ri_i(exc_ri_i), .exc_ov_i(exc_ov_i),
    .exc_trap_i(exc_trap_i), .exc_syscall_i(exc_syscall_i), .exc_eret_i(exc_eret_i),
    .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i),
    .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
    .stall_req_o(stall_req_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_data_o(cp0_data_o),
    .exc_code_o(exc_code_o), .exc_bd_o(exc_bd_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        flush;
    logic [4:0]  addr;
    logic [31:0] data;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void push(input logic fl, input logic [4:0] a, input logic [31:0] d);
    sb.push_back('{flush: fl, addr: a, data: d});
  endfunction

  // Monitor: every CP0 write or flush cycle must match the head of the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (cp0_we_o) begin
        if (sb.size() == 0) chk("cp0_unexpected", 64'(cp0_waddr_o), 64'hff);
        else begin
          mon_e = sb.pop_front();
          chk("cp0_kind", 64'(1'b0), 64'(mon_e.flush));
          chk("cp0_waddr", 64'(cp0_waddr_o), 64'(mon_e.addr));
          chk("cp0_wdata", 64'(cp0_data_o), 64'(mon_e.data));
        end
      end
      if (flush_o) begin
        if (sb.size() == 0) chk("flush_unexpected", 64'(new_pc_o), 64'hffff_ffff_ffff);
        else begin
          mon_e = sb.pop_front();
          chk("flush_kind", 64'(1'b1), 64'(mon_e.flush));
          chk("new_pc", 64'(new_pc_o), 64'(mon_e.data));
        end
      end
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && sb.size() != 0; i++) begin
      @(posedge clk); #2;
    end
    chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    sb.delete();
    @(posedge clk); #1;
  endtask

  // Drive one MEM event for a cycle; flags = {eret, syscall, trap, ov, ri}.
  task automatic fire(input logic [31:0] pc, input logic bd, input logic [4:0] flags);
    mem_valid_i = 1'b1; mem_pc_i = pc; mem_is_delayslot_i = bd;
    {exc_eret_i, exc_syscall_i, exc_trap_i, exc_ov_i, exc_ri_i} = flags;
    @(negedge clk);
    chk("stall_on_event", 64'(stall_req_o), 64'd1);
    @(posedge clk); #1;
    {exc_eret_i, exc_syscall_i, exc_trap_i, exc_ov_i, exc_ri_i} = '0;
    mem_valid_i = 1'b0;
    wb_cp0_we_i = 1'b0;
  endtask

  logic [31:0] exp_eret_pc;

  initial begin
    #12;
    chk("reset_outputs", 64'({flush_o, new_pc_o, cp0_we_o, cp0_waddr_o, cp0_data_o,
                               exc_code_o, exc_bd_o, stall_req_o}), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_stall", 64'(stall_req_o), 64'd0);

    // Syscall, not in delay slot.
    push(0, 5'd14, 32'h0000_0100); push(0, 5'd12, 32'h0000_0002); push(1, 0, 32'h0000_0020);
    fire(32'h0000_0100, 1'b0, 5'b01000);
    drain("syscall");
    chk("syscall_code", 64'(exc_code_o), 64'd8);
    chk("syscall_bd", 64'(exc_bd_o), 64'd0);

    // Overflow in a delay slot: EPC corrected back to the branch.
    push(0, 5'd14, 32'h0000_0200); push(0, 5'd12, 32'h0000_0002); push(1, 0, 32'h0000_0020);
    fire(32'h0000_0204, 1'b1, 5'b00010);
    drain("ov_bd");
    chk("ov_code", 64'(exc_code_o), 64'd12);
    chk("ov_bd", 64'(exc_bd_o), 64'd1);

    // Interrupt beats a simultaneous RI.
    status_i = 32'h1000_FF01; cause_i = 32'h0000_0400;
    push(0, 5'd14, 32'h0000_0040); push(0, 5'd12, 32'h1000_FF03); push(1, 0, 32'h0000_0020);
    fire(32'h0000_0040, 1'b0, 5'b00001);
    drain("int");
    chk("int_code", 64'(exc_code_o), 64'd0);

    // EXL already set masks the interrupt: RI taken.
    status_i = 32'h1000_FF03;
    push(0, 5'd14, 32'h0000_0044); push(0, 5'd12, 32'h1000_FF03); push(1, 0, 32'h0000_0020);
    fire(32'h0000_0044, 1'b0, 5'b00001);
    drain("ri");
    chk("ri_code", 64'(exc_code_o), 64'd10);

    // Trap beats syscall.
    status_i = 32'h0; cause_i = 32'h0;
    push(0, 5'd14, 32'h0000_0080); push(0, 5'd12, 32'h0000_0002); push(1, 0, 32'h0000_0020);
    fire(32'h0000_0080, 1'b0, 5'b01100);
    drain("trap");
    chk("trap_code", 64'(exc_code_o), 64'd13);

    // ERET with an in-flight EPC write; code/BD untouched.
    status_i = 32'h0000_FF03; epc_i = 32'h0000_0300;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h0000_0400;
`ifdef EXC_CP0_FWD_EN
    exp_eret_pc = 32'h0000_0400;
`else
    exp_eret_pc = 32'h0000_0300;
`endif
    push(0, 5'd12, 32'h0000_FF01); push(1, 0, exp_eret_pc);
    fire(32'h0000_0500, 1'b0, 5'b10000);
    drain("eret");
    chk("eret_code_kept", 64'(exc_code_o), 64'd13);
    status_i = 32'h0;

    // Event offered only during REDIRECT must be ignored.
    push(0, 5'd14, 32'h0000_0600); push(0, 5'd12, 32'h0000_0002); push(1, 0, 32'h0000_0020);
    fire(32'h0000_0600, 1'b0, 5'b01000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_valid_i = 1'b1; exc_trap_i = 1'b1;
    @(posedge clk); #1;
    mem_valid_i = 1'b0; exc_trap_i = 1'b0;
    drain("redirect_ignore");
    chk("redirect_ignore_code", 64'(exc_code_o), 64'd8);
    chk("redirect_ignore_idle", 64'(stall_req_o), 64'd0);

    // Reset during SET_STATUS clears everything immediately.
    push(0, 5'd14, 32'h0000_0700); push(0, 5'd12, 32'h0000_0002); push(1, 0, 32'h0000_0020);
    fire(32'h0000_0704, 1'b1, 5'b00010);
    @(posedge clk); #1;
    chk("in_set_status", 64'({cp0_we_o, cp0_waddr_o}), 64'({1'b1, 5'd12}));
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_outputs", 64'({flush_o, new_pc_o, cp0_we_o, cp0_waddr_o, cp0_data_o,
                                   exc_code_o, exc_bd_o, stall_req_o}), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Fresh syscall after reset runs the full sequence.
    push(0, 5'd14, 32'h0000_0100); push(0, 5'd12, 32'h0000_0002); push(1, 0, 32'h0000_0020);
    fire(32'h0000_0100, 1'b0, 5'b01000);
    drain("post_reset");
    chk("post_reset_code", 64'(exc_code_o), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0020: exception handler entry address.
REQ-002 SHALL have parameter DS_OFFSET, default 32'h0000_0004: delay-slot EPC correction.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port mem_valid_i  input  1: MEM-stage instruction valid.
REQ-006 SHALL have port mem_pc_i  input  32: MEM-stage instruction PC.
REQ-007 SHALL have port mem_is_delayslot_i  input  1: MEM instruction is in a delay slot.
REQ-008 SHALL have port exc_ri_i, exc_ov_i, exc_trap_i, exc_syscall_i, exc_eret_i  input  1 each: MEM-stage event flags.
REQ-009 SHALL have port status_i, cause_i, epc_i  input  32 each: current CP0 Status/Cause/EPC.
REQ-010 SHALL have port wb_cp0_we_i  input  1, wb_cp0_waddr_i  input  5, wb_cp0_data_i  input  32: in-flight CP0 write.
REQ-011 SHALL have port stall_req_o  output  1: pipeline hold request.
REQ-012 SHALL have port flush_o  output  1, new_pc_o  output  32: pipeline flush and redirect target.
REQ-013 SHALL have port cp0_we_o  output  1, cp0_waddr_o  output  5, cp0_data_o  output  32: CP0 write port.
REQ-014 SHALL have port exc_code_o  output  5, exc_bd_o  output  1: Cause ExcCode/BD sideband.

Function
REQ-015 Effective Status/EPC SHALL equal wb_cp0_data_i when wb_cp0_we_i=1 and waddr matches (12/14), else status_i/epc_i; effective Cause SHALL replace only bits 23, 22 and 9:8 from wb data on waddr 13.
REQ-016 Interrupt pending SHALL be Status[0]=1 & Status[1]=0 & |(Cause[15:8] & Status[15:8]).
REQ-017 Event priority, highest first: interrupt (code 0), RI (10), OV (12), TRAP (13), SYSCALL (8), ERET; only evaluated in IDLE with mem_valid_i=1.
REQ-018 FSM states SHALL be IDLE, SAVE_EPC, SET_STATUS, REDIRECT.
REQ-019 IDLE with exception: latch code, PC, BD; next state SAVE_EPC. IDLE with ERET only: latch effective EPC; next state SET_STATUS.
REQ-020 SAVE_EPC: cp0_we_o=1, waddr 14, data = mem_pc-DS_OFFSET if BD else mem_pc; next SET_STATUS.
REQ-021 SET_STATUS: cp0_we_o=1, waddr 12, data = effective Status with bit1 set (exception) or cleared (ERET); next REDIRECT.
REQ-022 REDIRECT: flush_o=1 for exactly one cycle, new_pc_o = EXC_VECTOR (exception) or latched EPC (ERET); next IDLE.
REQ-023 stall_req_o SHALL be combinational: 1 when state!=IDLE or an event is detected in IDLE.
REQ-024 exc_code_o/exc_bd_o SHALL update on exception latch and hold until next exception; ERET does not change them.
REQ-025 Event inputs SHALL be ignored outside IDLE; an event present in the REDIRECT cycle is not taken.
REQ-026 cp0_we_o SHALL be 0 in IDLE and REDIRECT; PC arithmetic is modulo 2^32.

Reset
REQ-027 rst=0 SHALL immediately force IDLE and zero flush_o, new_pc_o, cp0_we_o, cp0_waddr_o, cp0_data_o, exc_code_o, exc_bd_o, stall_req_o, and all latched PC/code/EPC registers, including mid-sequence.

Configuration
REQ-028 Macro EXC_CP0_FWD_EN defined: REQ-015 forwarding SHALL be present; undefined: status_i/cause_i/epc_i SHALL be used directly and wb_cp0_* SHALL be ignored.

Verification
REQ-029 Syscall at PC 0x0000_0100, BD=0 -> stall asserted; EPC write 0x0000_0100, Status write with bit1=1, then flush_o=1 with new_pc_o 0x0000_0020, exc_code_o=8.
REQ-030 OV at PC 0x0000_0204, BD=1 -> EPC write 0x0000_0200, exc_bd_o=1, exc_code_o=12.
REQ-031 Status=0x1000_FF01, Cause[10]=1, with simultaneous RI -> interrupt taken, exc_code_o=0; with Status bit1=1 -> RI taken, code 10.
REQ-032 ERET, epc_i=0x0000_0300 while WB writes EPC=0x0000_0400 -> Status bit1 cleared, new_pc_o=0x0000_0400 (0x0000_0300 without EXC_CP0_FWD_EN).
REQ-033 Reset asserted during SET_STATUS -> all outputs 0 at once; after release, a fresh syscall completes the full 3-cycle sequence.
